reg_arb: RTL
============

Name: reg_arb

Overview:
- Two-requester round-robin arbiter and sequencer for the shared register-file block (sel/wr/addr/wdata in, registered rdata and ready out).
- Each requester gets a simple req/done handshake.
- The block drives the register-file protocol: one-cycle write, read data one cycle after acceptance, sel held through the read-wait cycle so the register file can restore ready.
- Sits between two bus-side masters (e.g. CPU port and debug port) and one register-file instance.

Parameters:
- ADDR_WIDTH, 8, address width on all ports.
- DATA_WIDTH, 16, data width on all ports.
- TIMEOUT, 16, max CMD cycles waiting for m_ready before abort; legal range >= 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- req0, req1  in  1  request; held high with wrN/addrN/wdataN stable until doneN.
- wr0, wr1  in  1  1 = write, 0 = read.
- addr0, addr1  in  ADDR_WIDTH  target address.
- wdata0, wdata1  in  DATA_WIDTH  write data.
- done0, done1  out  1  one-cycle completion pulse.
- err0, err1  out  1  one-cycle pulse coincident with doneN when the transaction timed out.
- rdata0, rdata1  out  DATA_WIDTH  read data; valid while doneN=1 on a read, held until that port's next read.
- m_sel  out  1  register-file select.
- m_wr  out  1  register-file write enable.
- m_addr  out  ADDR_WIDTH  register-file address.
- m_wdata  out  DATA_WIDTH  register-file write data.
- m_rdata  in  DATA_WIDTH  register-file read data.
- m_ready  in  1  register-file ready.

Behaviour:
- All outputs are registered. Async reset values:
  - m_sel, m_wr, m_addr, m_wdata: 0.
  - done0/1, err0/1: 0.
  - rdata0/1: 0.
  - FSM: IDLE.
  - rr pointer: req0 has priority.
  - timeout counter: 0.
- FSM state IDLE (m_sel=0):
  - Eligible requesters: reqN=1 and doneN=0 this cycle. This masking prevents re-issuing a request whose done is just being seen.
  - One eligible: grant it.
  - Both eligible: grant the one not granted last. After reset, req0 wins.
  - On grant, latch wr/addr/wdata into the command registers, record the winner, update the rr pointer, go to CMD.
- FSM state CMD (m_sel=1, m_wr/m_addr/m_wdata from the command registers):
  - m_ready=1 at edge, write: pulse doneN next cycle, go to IDLE.
  - m_ready=1 at edge, read: go to RD_WAIT.
  - m_ready=0 at edge: increment the counter. If this was the TIMEOUT-th such cycle, pulse doneN and errN together, leave rdataN unchanged, go to IDLE.
- FSM state RD_WAIT (m_sel=1, m_wr=0, m_addr held):
  - At the next edge, capture m_rdata into rdataN, pulse doneN, go to IDLE.
  - m_ready is not checked in this state.
- Latency, measured from the edge where req is sampled in IDLE:
  - Write: done visible after 2 edges.
  - Read: done visible after 3 edges.
  - Minimum issue spacing: write 2 cycles, read 3 cycles.
- The timeout counter clears on entry to CMD. Counter width is clog2(TIMEOUT+1).
- m_wr is forced to 0 whenever m_sel=0 or the state is RD_WAIT.
- Requester dropping req before done: protocol violation. A latched command still completes and done still pulses.
- Reset asserted mid-operation:
  - Outputs go to reset values immediately.
  - No done/err pulse is issued for the abandoned transaction.
  - A write accepted on the same edge may or may not have landed.
- done0 and done1 are never high in the same cycle. At most one transaction is outstanding.

Test Plan:
- Reset, then req0 write addr 8'h10, data 16'hBEEF:
  - m_sel=1, m_wr=1, m_addr=8'h10 for exactly 1 cycle.
  - done0 pulses 2 edges after req is sampled; err0=0.
- req0 read addr 8'h10 after the write:
  - m_sel high 2 cycles (CMD, RD_WAIT), m_wr=0.
  - done0 pulses with rdata0=16'hBEEF; rdata0 holds after done0 falls.
- req1 read of unwritten addr 8'h22 after reset → done1 with rdata1=16'h1234 (register-file reset value).
- req0 and req1 both held high, both writes, 6 transactions:
  - Grants alternate 0,1,0,1,0,1, first grant is req0.
  - done0/done1 never coincide.
  - req0 re-asserted immediately after done0 is not reissued on the masking edge.
- Register-file stub holds m_ready=0 with TIMEOUT=4 → m_sel high 4 cycles, then done0 and err0 pulse together, rdata0 unchanged, FSM back in IDLE.
- rstn asserted asynchronously mid-cycle during RD_WAIT of a req1 read:
  - m_sel drops immediately and no done1 pulse occurs.
  - After release, a req1 read of 8'h10 (previously written with 16'hBEEF) returns 16'h1234, since reset also clears the register file.

Source files
------------

// File: rtl/reg_arb_if.sv
// Signal bundle between the two requesters, the arbiter and the shared register file.
// slave is the arbiter's view; master is the surrounding environment's view.
interface reg_arb_if #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 16
);
   logic                  req0;
   logic                  req1;
   logic                  wr0;
   logic                  wr1;
   logic [ADDR_WIDTH-1:0] addr0;
   logic [ADDR_WIDTH-1:0] addr1;
   logic [DATA_WIDTH-1:0] wdata0;
   logic [DATA_WIDTH-1:0] wdata1;
   logic                  done0;
   logic                  done1;
   logic                  err0;
   logic                  err1;
   logic [DATA_WIDTH-1:0] rdata0;
   logic [DATA_WIDTH-1:0] rdata1;

   logic                  m_sel;
   logic                  m_wr;
   logic [ADDR_WIDTH-1:0] m_addr;
   logic [DATA_WIDTH-1:0] m_wdata;
   logic [DATA_WIDTH-1:0] m_rdata;
   logic                  m_ready;

   modport slave (
      input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
      output done0, done1, err0, err1, rdata0, rdata1,
      output m_sel, m_wr, m_addr, m_wdata,
      input  m_rdata, m_ready
   );

   modport master (
      output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
      input  done0, done1, err0, err1, rdata0, rdata1,
      input  m_sel, m_wr, m_addr, m_wdata,
      output m_rdata, m_ready
   );
endinterface

// File: rtl/reg_arb.sv
// Two-requester round-robin arbiter and sequencer for a shared register file.
// One transaction outstanding at a time; writes take one CMD cycle, reads add a read-wait cycle.
module reg_arb #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned TIMEOUT    = 16
) (
   input logic     clk,
   input logic     rstn,
   reg_arb_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CMD     = 2'd1,
      RD_WAIT = 2'd2
   } state_t;

   typedef struct packed {
      logic                  wr;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
   } cmd_t;

   state_t           state;
   logic             owner;
   logic             last_gnt;
   logic [CNT_W-1:0] cnt;

   logic elig0_c;
   logic elig1_c;
   logic pick1_c;
   cmd_t grant_c;

   // A requester whose done is high this cycle is masked so it is not reissued.
   always_comb begin
      elig0_c = bus.req0 & ~bus.done0;
      elig1_c = bus.req1 & ~bus.done1;
      pick1_c = elig1_c & (~elig0_c | ~last_gnt);
      grant_c = cmd_t'{wr: bus.wr0, addr: bus.addr0, wdata: bus.wdata0};
      if (pick1_c) begin
         grant_c = cmd_t'{wr: bus.wr1, addr: bus.addr1, wdata: bus.wdata1};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         owner       <= 1'b0;
         last_gnt    <= 1'b1;
         cnt         <= '0;
         bus.m_sel   <= 1'b0;
         bus.m_wr    <= 1'b0;
         bus.m_addr  <= '0;
         bus.m_wdata <= '0;
         bus.done0   <= 1'b0;
         bus.done1   <= 1'b0;
         bus.err0    <= 1'b0;
         bus.err1    <= 1'b0;
         bus.rdata0  <= '0;
         bus.rdata1  <= '0;
      end else begin
         bus.done0 <= 1'b0;
         bus.done1 <= 1'b0;
         bus.err0  <= 1'b0;
         bus.err1  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (elig0_c || elig1_c) begin
                  state       <= CMD;
                  owner       <= pick1_c;
                  last_gnt    <= pick1_c;
                  cnt         <= '0;
                  bus.m_sel   <= 1'b1;
                  bus.m_wr    <= grant_c.wr;
                  bus.m_addr  <= grant_c.addr;
                  bus.m_wdata <= grant_c.wdata;
               end
            end
            CMD: begin
               if (bus.m_ready) begin
                  bus.m_wr <= 1'b0;
                  if (bus.m_wr) begin
                     state     <= IDLE;
                     bus.m_sel <= 1'b0;
                     if (owner) bus.done1 <= 1'b1;
                     else       bus.done0 <= 1'b1;
                  end else begin
                     state <= RD_WAIT;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
                  // Abort on the TIMEOUT-th stalled cycle; read data is left untouched.
                  if (cnt == CNT_W'(TIMEOUT - 1)) begin
                     state     <= IDLE;
                     bus.m_sel <= 1'b0;
                     bus.m_wr  <= 1'b0;
                     if (owner) begin
                        bus.done1 <= 1'b1;
                        bus.err1  <= 1'b1;
                     end else begin
                        bus.done0 <= 1'b1;
                        bus.err0  <= 1'b1;
                     end
                  end
               end
            end
            RD_WAIT: begin
               state     <= IDLE;
               bus.m_sel <= 1'b0;
               bus.m_wr  <= 1'b0;
               if (owner) begin
                  bus.rdata1 <= bus.m_rdata;
                  bus.done1  <= 1'b1;
               end else begin
                  bus.rdata0 <= bus.m_rdata;
                  bus.done0  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               bus.m_sel <= 1'b0;
               bus.m_wr  <= 1'b0;
            end
         endcase
      end
   end

endmodule
